// File: rtl/lz77_encoder_stream.sv
// lz77_encoder_stream: streaming LZ77 encoder emitting (offset, match_len, char_nxt) triples with backpressure.
module lz77_encoder_stream #(
  parameter int SEARCH_DEPTH = 9,
  parameter int LOOK_DEPTH = 8,
  parameter logic [7:0] TERM_CHAR = 8'h24,
  parameter int OFF_W = $clog2(SEARCH_DEPTH),
  parameter int LEN_W = $clog2(LOOK_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OFF_W-1:0] offset,
  output logic [LEN_W-1:0] match_len,
  output logic [7:0]       char_nxt,
  output logic             finish
);
  localparam int SC_W = $clog2(SEARCH_DEPTH + 1);
  localparam int LC_W = $clog2(LOOK_DEPTH + 1);
  localparam int WN = SEARCH_DEPTH + LOOK_DEPTH - 2;
  localparam int WI = $clog2(WN);
  typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_e;
  state_e state_q, state_d;
  logic [7:0] sb_q [SEARCH_DEPTH];
  logic [7:0] la_q [LOOK_DEPTH];
  logic [7:0] win [WN];
  logic [SC_W-1:0] scnt_q;
  logic [LC_W-1:0] lcnt_q;
  logic term_q;
  logic [OFF_W-1:0] j_q, off_q, best_off;
  logic [LEN_W-1:0] len_q, cand_len, best_len;
  logic [LEN_W:0] sh_q;
  logic [7:0] chr_q;
  logic run, cand_ok, better, last_j, in_fire, out_fire;
  // Search buffer followed by look-ahead, so a match may overlap into the look-ahead.
  for (genvar i = 0; i < WN; i++) begin : g_w
    if (i < SEARCH_DEPTH) begin : g_s
      assign win[i] = sb_q[i];
    end else begin : g_l
      assign win[i] = la_q[i-SEARCH_DEPTH];
    end
  end
  always_comb begin
    cand_len = '0;
    run = 1'b1;
    for (int k = 0; k < LOOK_DEPTH - 1; k++) begin
      run = run && (int'(lcnt_q) > k + 1) && (win[WI'(int'(j_q) + k)] == la_q[k]);
      if (run) cand_len = LEN_W'(k + 1);
    end
  end
  assign cand_ok = int'(j_q) >= SEARCH_DEPTH - int'(scnt_q);
  assign better = cand_ok && (cand_len > len_q);
  assign best_len = better ? cand_len : len_q;
  assign best_off = better ? OFF_W'(SEARCH_DEPTH - 1 - int'(j_q)) : off_q;
  assign last_j = int'(j_q) == SEARCH_DEPTH - 1;
  assign in_ready = !reset && !term_q &&
                    (state_q == SHIFT || (state_q == FILL && lcnt_q < LC_W'(LOOK_DEPTH)));
  assign out_valid = state_q == EMIT;
  assign finish = state_q == DONE;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign offset = off_q;
  assign match_len = len_q;
  assign char_nxt = chr_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    state_d = (lcnt_q == LC_W'(LOOK_DEPTH) || term_q) ? SEARCH : FILL;
      SEARCH:  state_d = last_j ? EMIT : SEARCH;
      EMIT:    state_d = !out_fire ? EMIT : (chr_q == TERM_CHAR) ? DONE : SHIFT;
      SHIFT:   state_d = (sh_q == (LEN_W+1)'(1)) ? FILL : SHIFT;
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      for (int i = 0; i < SEARCH_DEPTH; i++) sb_q[i] <= '0;
      for (int i = 0; i < LOOK_DEPTH; i++) la_q[i] <= '0;
      scnt_q <= '0;
      lcnt_q <= '0;
      term_q <= 1'b0;
      j_q <= '0;
      off_q <= '0;
      len_q <= '0;
      sh_q <= '0;
      chr_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FILL: begin
          if (in_fire) begin
            la_q[LEN_W'(lcnt_q)] <= in_data;
            lcnt_q <= lcnt_q + 1'b1;
            term_q <= in_data == TERM_CHAR;
          end
          if (state_d == SEARCH) begin
            j_q <= '0;
            off_q <= '0;
            len_q <= '0;
          end
        end
        SEARCH: begin
          j_q <= j_q + 1'b1;
          off_q <= best_off;
          len_q <= best_len;
          if (last_j) chr_q <= la_q[best_len];
        end
        EMIT: if (out_fire) sh_q <= {1'b0, len_q} + 1'b1;
        SHIFT: begin
          for (int i = 0; i < SEARCH_DEPTH - 1; i++) sb_q[i] <= sb_q[i+1];
          sb_q[SEARCH_DEPTH-1] <= la_q[0];
          scnt_q <= (scnt_q == SC_W'(SEARCH_DEPTH)) ? scnt_q : scnt_q + 1'b1;
          for (int i = 0; i < LOOK_DEPTH - 1; i++) la_q[i] <= la_q[i+1];
          // A char accepted while shifting lands at the tail slot vacated by the shift.
          if (in_fire) begin
            la_q[LEN_W'(lcnt_q - 1'b1)] <= in_data;
            term_q <= in_data == TERM_CHAR;
          end else begin
            lcnt_q <= lcnt_q - 1'b1;
          end
          sh_q <= sh_q - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lz77_encoder_stream.sv
// tb_lz77_encoder_stream: random handshake stimulus checked against a behavioural LZ77 reference.
module tb_lz77_encoder_stream;
  localparam int S = 9;
  localparam int L = 8;
  localparam int OW = $clog2(S);
  localparam int LW = $clog2(L);
  typedef struct {int off; int len; int ch;} trip_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, finish;
  logic [OW-1:0] offset;
  logic [LW-1:0] match_len;
  logic [7:0] char_nxt;
  int checks = 0;
  int errors = 0;
  logic [7:0] s_q[$];
  trip_t exp_q[$];
  always #5 clk = ~clk;
  lz77_encoder_stream dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .offset(offset), .match_len(match_len),
    .char_nxt(char_nxt), .finish(finish)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    check(tag, {in_ready, out_valid, finish, offset, match_len, char_nxt}, 0);
  endtask
  task automatic load(input string str);
    s_q.delete();
    for (int i = 0; i < str.len(); i++) s_q.push_back(str[i]);
  endtask
  // Greedy LZ77 over the whole string: window = last S chars, look-ahead = next min(L, rest) chars.
  task automatic build_model();
    int pos, n, lan, cap, best, boff, len, dmax;
    bit done;
    exp_q.delete();
    n = s_q.size();
    pos = 0;
    done = 0;
    while (!done) begin
      lan = (n - pos < L) ? n - pos : L;
      cap = lan - 1;
      best = 0;
      boff = 0;
      dmax = (pos < S) ? pos : S;
      for (int d = dmax; d >= 1; d--) begin
        len = 0;
        while (len < cap && s_q[pos-d+len] == s_q[pos+len]) len++;
        if (len > best) begin
          best = len;
          boff = d - 1;
        end
      end
      exp_q.push_back('{boff, best, int'(s_q[pos+best])});
      done = s_q[pos+best] == 8'h24;
      pos += best + 1;
    end
  endtask
  task automatic run(input int gap, input int bp, input bit do_rst);
    int idx, nt, cyc;
    bit stall;
    logic [31:0] ptrip;
    idx = 0; nt = 0; cyc = 0; stall = 0; ptrip = 0;
    build_model();
    if (do_rst) begin
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
    end
    while (!finish && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_trip", {offset, match_len, char_nxt}, ptrip);
      end
      in_valid = $urandom_range(0, 99) >= gap;
      in_data = (idx < s_q.size()) ? s_q[idx] : 8'h7a;
      out_ready = $urandom_range(0, 99) >= bp;
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (nt < exp_q.size()) begin
          check("offset", offset, exp_q[nt].off);
          check("match_len", match_len, exp_q[nt].len);
          check("char_nxt", char_nxt, exp_q[nt].ch);
        end else begin
          check("extra_trip", nt, exp_q.size());
        end
        nt++;
      end
      stall = out_valid && !out_ready;
      ptrip = {offset, match_len, char_nxt};
    end
    check("finish", finish, 1);
    check("trip_cnt", nt, exp_q.size());
    check("accepted", idx, s_q.size());
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'h7a;
      #1;
      check("done_in_ready", in_ready, 0);
      check("done_out_valid", out_valid, 0);
      check("done_finish", finish, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask
  initial begin
    int n;
    #2 chk_zero("reset");
    @(negedge clk) reset = 1'b0;
    load("abcabc$");  run(0, 0, 1);
    load("aaaa$");    run(0, 0, 1);
    load("ababab$");  run(0, 0, 1);
    load("$");        run(0, 0, 1);
    load("abcabc$");  run(75, 0, 1);
    load("abcabc$");  run(0, 85, 1);
    load("aaaaaaaaaaaaaaaaaaaa$"); run(30, 30, 1);
    for (int t = 0; t < 8; t++) begin
      s_q.delete();
      n = $urandom_range(0, 40);
      repeat (n) s_q.push_back(8'($urandom_range(97, 99)));
      s_q.push_back(8'h24);
      run($urandom_range(0, 60), $urandom_range(0, 60), 1);
    end
    // Reset in the middle of a search, then a fresh stream with no reset of its own.
    load("abcabc$");
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    begin
      int idx;
      idx = 0;
      out_ready = 1'b1;
      repeat (11) begin
        @(negedge clk);
        in_valid = idx < s_q.size();
        in_data = (idx < s_q.size()) ? s_q[idx] : 8'h7a;
        #1;
        if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0;
      check("mid_out_valid", out_valid, 0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge clk) reset = 1'b0;
    load("xy$");
    run(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
